fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word reads to instruction memory over a
//  valid/ready request channel, and buffers in-order responses in a small FIFO. It presents
//  {pc, instr} to decode (imm_gen, regfile, control) over a valid/ready channel.
//  Branch/jump redirects from execute flush the buffer and discard stale in-flight responses.
// PARAMETERS
//  XLEN        32            datapath/address width
//  RESET_PC    32'h0000_0000 first fetch address after reset
//  FIFO_DEPTH  2             fetch buffer entries; also max outstanding+buffered requests
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     async reset, active low
//  imem_req_valid  out  1     read request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  word-aligned fetch address (= pc)
//  imem_rsp_valid  in   1     read data valid; in order, >=1 cycle after acceptance, no backpressure
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     execute redirects fetch (taken branch/jump)
//  redirect_pc     in   XLEN  new PC; bits [1:0] forced to 0
//  id_valid        out  1     decode output valid (FIFO not empty)
//  id_ready        in   1     decode accepts
//  id_instr        out  32    instruction at FIFO head
//  id_pc           out  XLEN  PC of id_instr
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): pc=resp_pc=RESET_PC, FIFO empty, outstanding=0,
//    drop_cnt=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
//  - Issue: imem_req_valid=1 when drop_cnt==0 and (outstanding+count < FIFO_DEPTH, or ==FIFO_DEPTH
//    with id pop this cycle). No issue in a cycle with redirect_valid=1.
//    Accepted request (valid&ready): pc += 4, outstanding += 1. pc wraps 0xFFFF_FFFC -> 0.
//  - Response: if drop_cnt>0, drop_cnt -= 1 and data discarded; else push {resp_pc, data},
//    resp_pc += 4. Either way outstanding -= 1. Push never overflows (credit rule above).
//  - Pop: id_valid & id_ready removes head. id_* registered from FIFO storage: with 1-cycle memory,
//    rsp at cycle t -> id_valid at t+1. Sustained 1 instr/cycle with DEPTH=2, ready memory, id_ready=1.
//  - Redirect (highest priority): next cycle pc=resp_pc=redirect_pc&~3, FIFO flushed, id_valid=0,
//    drop_cnt = outstanding after this cycle's rsp/req updates (same-cycle rsp discarded).
//    A pop coincident with redirect completes (decode took it); redirect wins over everything else.
//  - Redirect while drop_cnt>0: drop_cnt accumulates; new path issues only once drop_cnt==0.
//  - Reset mid-operation: state cleared immediately; memory is reset alongside, so no stale rsps.
//  - imem_rsp_valid with outstanding==0 is a protocol error: ignored, assertion in sim.
// STRUCTURE
//  - riscv_pkg: XLEN, ILEN=32, RESET_PC default, NOP=32'h0000_0013, fetch entry struct {pc,instr}.
//  - Sub-module fetch_fifo: sync FIFO (DEPTH, WIDTH), push/pop/flush, count, empty/full; pop+push
//    when full is legal. Top holds pc, resp_pc, outstanding, drop_cnt and issue logic.
// TESTING
//  1 Reset release, 1-cycle mem, id_ready=1 -> req addrs 0,4,8,..; id_pc 0,4,8 one per cycle; no gaps.
//  2 id_ready=0 for 10 cycles -> exactly 2 requests issued, id holds pc=0 stable; on release
//    stream resumes in order, no loss or duplicates.
//  3 Redirect to 0x100 with 2 outstanding (3-cycle mem) -> those 2 rsps dropped; first id_pc=0x100,
//    then 0x104.
//  4 redirect_pc=0x203 -> fetch addr 0x200, id_pc 0x200.
//  5 Two redirects 1 cycle apart (0x40, then 0x80) -> only 0x80 path reaches decode.
//  6 Redirect to 0xFFFF_FFFC -> addrs 0xFFFF_FFFC, 0x0; rst_n low mid-stream -> id_valid=0, restart at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   NOP               : canonical ADDI x0,x0,0 encoding
//   fetch_entry_t     : {pc, instr} pair handed from fetch to decode
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer.
//   clk, rst_n        : clock, async active-low reset
//   i_push/i_push_data: write one entry at the tail
//   i_pop             : remove the head entry (ignored when empty)
//   i_flush           : discard all entries; overrides push and pop
//   o_head            : entry at the head (stale when empty)
//   o_count/o_empty/o_full : occupancy
// Push and pop in the same cycle while full is legal.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    // A full buffer accepts a write only when the head leaves in the same cycle.
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
//   clk, rst_n                      : clock, async active-low reset
//   imem_req_valid/ready/addr       : word read request to instruction memory (addr = pc)
//   imem_rsp_valid/data             : in-order read responses, no backpressure
//   redirect_valid/pc               : taken branch/jump from execute (pc[1:0] ignored)
//   id_valid/ready, id_instr, id_pc : buffered instruction stream to decode
// Requests are credit-limited so that outstanding + buffered never exceeds FIFO_DEPTH.
// A redirect flushes the buffer and arms drop_cnt to swallow responses still in flight.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = XLEN + ILEN;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_resp_pc_next;
    logic [CNT_W-1:0] w_outstanding_next;
    logic [CNT_W-1:0] w_drop_cnt_next;

    logic [XLEN-1:0]  w_redirect_aligned;
    logic [CNT_W:0]   w_credit_sum;
    logic             w_credit_ok;
    logic             w_req_fire;
    logic             w_rsp_ok;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;

    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // A slot freed by this cycle's pop may be reused by this cycle's request.
    assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit_ok  = (w_credit_sum < (CNT_W+1)'(FIFO_DEPTH)) ||
                          ((w_credit_sum == (CNT_W+1)'(FIFO_DEPTH)) && w_pop);

    // rst_n gating keeps the request low while reset is held.
    assign imem_req_valid = rst_n && (r_drop_cnt == '0) && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign w_rsp_ok   = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop = w_rsp_ok && (r_drop_cnt != '0);
    assign w_push     = w_rsp_ok && (r_drop_cnt == '0) && !redirect_valid;

    assign w_pop = !w_fifo_empty && id_ready;

    always_comb begin
        w_pc_next          = r_pc;
        w_resp_pc_next     = r_resp_pc;
        w_outstanding_next = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_ok);
        w_drop_cnt_next    = r_drop_cnt - CNT_W'(w_rsp_drop);
        if (redirect_valid) begin
            w_pc_next       = w_redirect_aligned;
            w_resp_pc_next  = w_redirect_aligned;
            // Everything still in flight belongs to the old path.
            w_drop_cnt_next = w_outstanding_next;
        end else begin
            if (w_req_fire) w_pc_next      = r_pc + XLEN'(4);
            if (w_push)     w_resp_pc_next = r_resp_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_resp_pc     <= w_resp_pc_next;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_resp_pc, imem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign id_valid = !w_fifo_empty;
    // Zero the decode payload when nothing is buffered.
    assign id_pc    = w_fifo_empty ? '0 : w_head[ENT_W-1:ILEN];
    assign id_instr = w_fifo_empty ? '0 : w_head[ILEN-1:0];

    rsp_without_request: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (r_outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sb[$];        // expected id_pc sequence
    logic [31:0] req_log[$];   // accepted request addresses since last reset

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    mem_cyc = 0;
    int    mem_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory model: responses driven at the falling edge, requests sampled late in the cycle.
    always begin
        @(negedge clk);
        mem_cyc++;
        if (mq.size() > 0 && mq[0].due <= mem_cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #4;
        if (!rst_n) begin
            mq.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: mem_cyc + mem_lat});
            req_log.push_back(imem_req_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at negedge+1 with inputs set; checks this cycle's decode transfer.
    task automatic step();
        logic [31:0] e;
        #2;
        if (rst_n && id_valid && id_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL extra_pop observed id_pc=%h expected no transfer", id_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("id_pc", id_pc, e);
                chk("id_instr", id_instr, mem_word(e));
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        id_ready = 1'b0;
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        chk("rst_id_valid",  {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr",  id_instr, 32'h0);
        chk("rst_id_pc",     id_pc, 32'h0);
        sb.delete();
        @(negedge clk); #1;
        @(negedge clk); #1;
        req_log.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int mark;
        @(negedge clk); #1;

        // 1: streaming from reset, 1-cycle memory
        mem_lat = 1;
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 16; i++) sb.push_back(32'(i * 4));
        chk("t1_valid_c0", {31'd0, id_valid}, 32'd0);
        step();
        chk("t1_valid_c1", {31'd0, id_valid}, 32'd0);
        step();
        chk("t1_valid_c2", {31'd0, id_valid}, 32'd1);
        drain(40, n);
        chk("t1_no_gaps", 32'(n), 32'd16);
        for (int i = 0; i < 4; i++) chk("t1_req_addr", req_log[i], 32'(i * 4));

        // 2: decode stalled, credit limit
        do_reset();
        repeat (10) step();
        chk("t2_req_count", 32'(req_log.size()), 32'd2);
        chk("t2_hold_valid", {31'd0, id_valid}, 32'd1);
        chk("t2_hold_pc", id_pc, 32'h0);
        chk("t2_hold_instr", id_instr, mem_word(32'h0));
        for (int i = 0; i < 10; i++) sb.push_back(32'(i * 4));
        id_ready = 1'b1;
        drain(30, n);

        // 3: redirect with 2 outstanding, 3-cycle memory
        mem_lat = 3;
        do_reset();
        id_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        mark = req_log.size();
        chk("t3_outstanding_reqs", 32'(mark), 32'd2);
        step();
        redirect_valid = 1'b0;
        chk("t3_blocked_1", {31'd0, imem_req_valid}, 32'd0);
        step();
        chk("t3_blocked_2", {31'd0, imem_req_valid}, 32'd0);
        step();
        chk("t3_new_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t3_new_addr", imem_req_addr, 32'h100);
        drain(40, n);
        chk("t3_log_first", req_log[mark], 32'h100);

        // 4: misaligned redirect target
        mem_lat = 1;
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        sb.push_back(32'h200);
        sb.push_back(32'h204);
        mark = req_log.size();
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        drain(20, n);
        chk("t4_fetch_addr", req_log[mark], 32'h200);

        // 5: two redirects close together; only the second path is delivered
        mem_lat = 3;
        do_reset();
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        sb.push_back(32'h80);
        sb.push_back(32'h84);
        sb.push_back(32'h88);
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        drain(40, n);

        // 6: address wrap, then reset mid-stream
        mem_lat = 1;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        mark = req_log.size();
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        drain(20, n);
        chk("t6_wrap_addr0", req_log[mark], 32'hFFFF_FFFC);
        chk("t6_wrap_addr1", req_log[mark + 1], 32'h0);
        step();
        step();
        do_reset();
        for (int i = 0; i < 3; i++) sb.push_back(32'(i * 4));
        id_ready = 1'b1;
        drain(20, n);
        chk("t6_restart_addr", req_log[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
